// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Width of the bit counter that walks 0..WIDTH-1.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// Single-bit full-adder cell; the only arithmetic in the serial datapath.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock under start/done.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int             CW   = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, nstate;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic [CW-1:0]    cnt;
  logic             cy;
  logic             fs, fc;
  logic             load, fin;

  fa_bit u_fa (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .cin   (cy),
    .sum   (fs),
    .carry (fc)
  );

  always_comb begin
    nstate = state;
    load   = 1'b0;
    fin    = 1'b0;
    case (state)
      IDLE: if (start) begin
        load   = 1'b1;
        nstate = RUN;
      end
      RUN: if (cnt == LAST) begin
        fin    = 1'b1;
        nstate = DONE;
      end
      DONE: begin
        // A start in the DONE cycle chains straight into the next operation.
        load   = start;
        nstate = start ? RUN : IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      cnt   <= '0;
      cy    <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= nstate;
      if (load) begin
        a_sr <= a;
        b_sr <= b;
        cy   <= cin;
        cnt  <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        s_sr <= {fs, s_sr[WIDTH-1:1]};
        cy   <= fc;
        cnt  <= cnt + 1'b1;
        if (fin) begin
          sum  <= {fs, s_sr[WIDTH-1:1]};
          cout <= fc;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last bit, cy is the carry into the MSB.
          ovf  <= cy ^ fc;
`endif
        end
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed vectors plus WIDTH=2 exhaustive.
module tb_serial_adder;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start2 = 1'b0, cin2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t q8[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf8),
`endif
    .cout(cout8)
  );

  serial_adder #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf2),
`endif
    .cout(cout2)
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on every done pulse, independent of the stimulus thread.
  always @(negedge clk) begin
    if (!rst && done8) begin
      if (q8.size() == 0) chk("u8 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("u8 sum", {24'd0, sum8}, {24'd0, e.sum});
        chk("u8 cout", {31'd0, cout8}, {31'd0, e.cout});
        chk("u8 done cycle", cyc, e.cyc);
        chk("u8 busy with done", {31'd0, busy8}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("u8 ovf", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done2) begin
      if (q2.size() == 0) chk("u2 unexpected done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q2.pop_front();
        chk("u2 {cout,sum}", {29'd0, cout2, sum2}, {29'd0, e.cout, e.sum[1:0]});
        chk("u2 done cycle", cyc, e.cyc);
        chk("u2 busy with done", {31'd0, busy2}, 32'd0);
      end
    end
  end

  // Caller sits away from an edge; returns #1 after the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        input logic [7:0] s, input logic co, input logic ov);
    exp_t e;
    a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    e.sum = s; e.cout = co; e.ovf = ov; e.cyc = cyc + 8;
    q8.push_back(e);
  endtask

  task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic ci);
    exp_t e;
    logic [2:0] r;
    r = {1'b0, a} + {1'b0, b} + {2'b0, ci};
    a2 = a; b2 = b; cin2 = ci; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    e.sum = {6'd0, r[1:0]}; e.cout = r[2]; e.ovf = 1'b0; e.cyc = cyc + 2;
    q2.push_back(e);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    exp_t e;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy8}, 32'd0);
    chk("reset done", {31'd0, done8}, 32'd0);
    chk("reset sum", {24'd0, sum8}, 32'd0);
    chk("reset cout", {31'd0, cout8}, 32'd0);
    chk("reset ovf", {31'd0, ovf8}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic carry ripple.
    issue8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    repeat (9) @(posedge clk); #1;

    // Full wrap, then a second operation issued in the DONE cycle.
    issue8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    repeat (8) @(posedge clk); #1;
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    repeat (9) @(posedge clk); #1;

    // start held 20 edges: accepts at E0, E9, E18.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) begin
      e.sum = 8'h46; e.cout = 1'b0; e.ovf = 1'b0; e.cyc = c0 + 8 + 9 * k;
      q8.push_back(e);
    end
    repeat (19) @(posedge clk); #1;
    start8 = 1'b0;
    repeat (9) @(posedge clk); #1;

    // start mid-RUN is ignored; sum holds the previous result meanwhile.
    issue8(8'h55, 8'h2A, 1'b1, 8'h80, 1'b0, 1'b1);
    repeat (3) @(posedge clk); #1;
    chk("sum held in RUN", {24'd0, sum8}, 32'h46);
    chk("busy in RUN", {31'd0, busy8}, 32'd1);
    a8 = 8'h00; b8 = 8'h00; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (5) @(posedge clk); #1;

    // Signed overflow cases.
    issue8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    repeat (9) @(posedge clk); #1;
    issue8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    repeat (9) @(posedge clk); #1;
    issue8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
    repeat (9) @(posedge clk); #1;

    // Reset on RUN edge 4 aborts the operation.
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", {31'd0, busy8}, 32'd0);
    chk("abort done", {31'd0, done8}, 32'd0);
    chk("abort sum", {24'd0, sum8}, 32'd0);
    chk("abort cout", {31'd0, cout8}, 32'd0);
    chk("abort ovf", {31'd0, ovf8}, 32'd0);
    repeat (12) @(posedge clk); #1;
    chk("abort stays idle", {30'd0, busy8, done8}, 32'd0);

    // Exhaustive WIDTH=2.
    for (int av = 0; av < 4; av++)
      for (int bv = 0; bv < 4; bv++)
        for (int cv = 0; cv < 2; cv++)
          issue2(av[1:0], bv[1:0], cv[0]);

    repeat (4) @(posedge clk); #1;
    chk("u8 queue drained", q8.size(), 32'd0);
    chk("u2 queue drained", q2.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around one single-bit full-adder cell and a carry flip-flop. It accepts two operands and a carry-in under a start/done handshake, then adds one bit per clock, LSB first. It sits directly downstream of the combinational full adder: it consumes that cell's sum and carry every cycle and turns it into a multi-bit sequential datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A; captured on the accepted start edge.
- b  in  WIDTH  operand B; captured on the accepted start edge.
- cin  in  1  carry-in; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; sum and cout are valid from this cycle.
- sum  out  WIDTH  result register.
- cout  out  1  final carry-out.
- ovf  out  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. The internal shift registers, carry flip-flop and bit counter are cleared.
- IDLE: if start=1, load a and b into the shift registers, load cin into the carry flip-flop, clear the counter, and go to RUN.
- RUN, each edge:
  - The full-adder cell adds the operand LSBs and the carry flip-flop.
  - Its sum bit shifts into the MSB of the internal sum shift register.
  - Its carry goes into the carry flip-flop.
  - Both operand registers shift right by 1, and the counter increments.
- On the edge where counter==WIDTH-1:
  - Copy the completed shift register to sum and the final carry to cout.
  - Go to DONE.
- DONE, one cycle only:
  - start=1 loads new operands and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start while in RUN is ignored. It is not queued.
- sum and cout change only on the edge entering DONE. They hold their value through any later IDLE and RUN periods.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). No truncation is reported except through cout (and ovf).

## Timing
- If start is accepted at edge E0, busy is high from E0 to E_WIDTH, and done is high for exactly one cycle after E_WIDTH. Latency is WIDTH clock edges from the start sample to done.
- With back-to-back starts, one operation completes every WIDTH+1 cycles.
- rst high on any edge overrides everything, including mid-RUN and in DONE. The operation is aborted, all outputs return to their reset values, and the next cycle is in IDLE.
- done and busy are never high in the same cycle.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - An ovf output and an internal register holding the carry into the MSB are added.
  - ovf = carry-into-MSB XOR cout, updated on the same edge as sum.
  - Reset value of ovf is 0.
- SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic are absent, and all other behaviour is identical.

## Structure
- Package serial_adder_pkg holds:
  - the state enum (IDLE, RUN, DONE) and its encoding;
  - the default WIDTH constant;
  - a function giving the counter width, $clog2(WIDTH).
- One sub-module, fa_bit: purely combinational, with inputs a, b, cin and outputs sum, carry. It is instantiated once, and the top level holds all registers and the FSM.

## Test plan
- WIDTH=8; a=0x0F, b=0x01, cin=0; start pulse → done exactly 8 edges after the start edge, sum=0x10, cout=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 issued in the DONE cycle → accepted, sum=0xFF, cout=1 after a further 8 edges.
- Hold start high for 20 cycles with a=0x12, b=0x34 → a new operation every 9 cycles, each giving sum=0x46; busy never overlaps done.
- Mid-RUN (after 3 edges) change a/b and pulse start → ignored, result is from the original operands; separately, assert rst on edge 4 of RUN → next cycle busy=0, done=0, sum=0, state IDLE.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, ovf=1; a=0x80, b=0x80 → sum=0x00, cout=1, ovf=1; a=0x01, b=0x01 → ovf=0.
- Exhaustive check at WIDTH=2: all 32 (a,b,cin) combinations → {cout,sum} equals a+b+cin for every one.
